// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: one outstanding imem request, predictor-steered
// next PC, and a small registered FIFO toward decode that is flushed on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] pred_instr,
  output logic [31:0] pred_pc,
  input  logic [31:0] pred_next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pred_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       pc_reg, pc_next;
  logic [31:0]       instr_mem [FIFO_DEPTH];
  logic [31:0]       pc_mem    [FIFO_DEPTH];
  logic [31:0]       pred_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_plus;
  logic              resp_take, push, pop, credit, handshake;
  logic [31:0]       next_fetch;

  assign resp_take  = (state_reg == WAIT) && imem_resp_valid;
  assign pop        = dec_valid && dec_ready;
  assign push       = resp_take && !redirect_valid;
  // Credit sees this cycle's pop and the push of a landing response, so a
  // back-to-back request is only issued when its result is sure to fit.
  assign count_plus = count_reg - CNT_W'(pop) + CNT_W'(resp_take);
  assign credit     = count_plus < DEPTH_C;
  assign next_fetch = pred_next_pc & ALIGN_MASK;

  assign imem_req_valid = rst_n && credit &&
                          ((state_reg == REQ) || resp_take);
  assign imem_req_addr  = resp_take ? next_fetch : pc_reg;
  assign handshake      = imem_req_valid && imem_req_ready;

  // The predictor only sees a live instruction while a response can land.
  assign pred_instr = (state_reg == WAIT) ? imem_resp_data : '0;
  assign pred_pc    = (state_reg == WAIT) ? pc_reg : '0;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      REQ:  if (handshake) state_next = WAIT;
      WAIT: begin
        if (imem_resp_valid) begin
          pc_next    = next_fetch;
          state_next = handshake ? WAIT : REQ;
        end
      end
      DROP: if (imem_resp_valid) state_next = REQ;
      default: state_next = REQ;
    endcase
    if (redirect_valid) begin
      pc_next = redirect_pc & ALIGN_MASK;
      if (handshake)                 state_next = DROP;
      else if (state_reg == REQ)     state_next = REQ;
      else if (imem_resp_valid)      state_next = REQ;
      else                           state_next = DROP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= REQ;
      pc_reg     <= RESET_PC & ALIGN_MASK;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (redirect_valid) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg - CNT_W'(pop) + CNT_W'(push);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_resp_data;
      pc_mem[wr_ptr_reg]    <= pc_reg;
      pred_mem[wr_ptr_reg]  <= next_fetch;
    end
  end

  assign dec_valid   = (count_reg != '0);
  assign dec_instr   = dec_valid ? instr_mem[rd_ptr_reg] : '0;
  assign dec_pc      = dec_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign dec_pred_pc = dec_valid ? pred_mem[rd_ptr_reg]  : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory and predictor models, expected request
// addresses and decode entries queued by the stimulus, checked by a monitor.
`timescale 1ns/100ps
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL16 = 32'h0100_006F;
  localparam logic [31:0] BEQF  = 32'h0000_0463;
  localparam logic [31:0] BEQB  = 32'hFE00_0CE3;
  localparam logic [31:0] STALE = 32'h1234_5013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] pred_instr, pred_pc, pred_next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pred_pc;

  int total = 0;
  int bad   = 0;
  int hs_count  = 0;
  int hs_target = 0;
  int mem_lat   = 1;
  logic [31:0] req_q[$];
  dec_t        dec_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .pred_instr(pred_instr), .pred_pc(pred_pc), .pred_next_pc(pred_next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pred_pc(dec_pred_pc)
  );

  always #5 clk = ~clk;

  // Static predictor: JAL taken, backward branches taken, else fall through.
  function automatic logic [31:0] predict(input logic [31:0] i, input logic [31:0] pc);
    logic [31:0] imm;
    imm = 32'd4;
    if (i[6:0] == 7'h6F)
      imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    else if (i[6:0] == 7'h63 && i[31])
      imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    return pc + imm;
  endfunction

  assign pred_next_pc = predict(pred_instr, pred_pc);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h08:  return JAL16;
      32'h18:  return BEQF;
      32'h20:  return BEQB;
      32'h208: return STALE;
      default: return NOP;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory keeps a pending reply across reset so a stale response can appear.
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_pend && mem_cnt == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_pend = 1'b0;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_pend) mem_cnt--;
      end
      #2;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        mem_pend = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = mem_lat;
      end
    end
  end

  initial begin
    imem_req_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      imem_req_ready = (hs_count < hs_target);
    end
  end

  // Monitor: pops expectations on every request handshake and decode pop.
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0, prev_rst = 1'b0;
  logic [31:0] prev_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        total++;
        if (dut.count_reg > DEPTH) begin
          bad++;
          $display("FAIL fifo_overflow: count %0d limit %0d", dut.count_reg, DEPTH);
        end
        if (prev_rst && prev_valid && !prev_ready && !prev_redir) begin
          check32("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
          check32("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (imem_req_valid && imem_req_ready) begin
          hs_count++;
          if (req_q.size() == 0) check32("req_unexpected", imem_req_addr, 32'hFFFF_FFFF);
          else check32("req_addr", imem_req_addr, req_q.pop_front());
        end
        if (dec_valid && dec_ready) begin
          if (dec_q.size() == 0) check32("dec_unexpected", dec_pc, 32'hFFFF_FFFF);
          else begin
            dec_t e;
            e = dec_q.pop_front();
            $display("pop pc=%h instr=%h pred=%h", dec_pc, dec_instr, dec_pred_pc);
            check32("dec_instr", dec_instr, e.instr);
            check32("dec_pc", dec_pc, e.pc);
            check32("dec_pred_pc", dec_pred_pc, e.pred);
          end
        end
      end
      prev_valid = imem_req_valid;
      prev_ready = imem_req_ready;
      prev_redir = redirect_valid;
      prev_rst   = rst_n;
      prev_addr  = imem_req_addr;
    end
  end

  task automatic wait_hs(input int target);
    int t;
    t = 0;
    while (hs_count < target && t < 100) begin
      @(negedge clk);
      #3;
      t++;
    end
    check32("wait_hs_timeout", hs_count, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check32({tag, "_dec_valid"}, {31'd0, dec_valid}, 32'd0);
    check32({tag, "_dec_instr"}, dec_instr, 32'd0);
    check32({tag, "_dec_pc"}, dec_pc, 32'd0);
    check32({tag, "_dec_pred_pc"}, dec_pred_pc, 32'd0);
    check32({tag, "_pred_instr"}, pred_instr, 32'd0);
    check32({tag, "_pred_pc"}, pred_pc, 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check32({tag, "_req_left"}, req_q.size(), 32'd0);
    check32({tag, "_dec_left"}, dec_q.size(), 32'd0);
  endtask

  task automatic exp_dec(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pred);
    dec_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pred  = pred;
    dec_q.push_back(e);
  endtask

  int base;
  initial begin
    rst_n = 1'b0;
    dec_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    #3;
    check_reset_outputs("rst0");

    // Straight line, JAL, forward and backward branches with 1-cycle memory.
    @(negedge clk);
    rst_n = 1'b1;
    req_q = '{32'h00, 32'h04, 32'h08, 32'h18, 32'h1C, 32'h20, 32'h18, 32'h1C, 32'h20};
    exp_dec(NOP, 32'h00, 32'h04);
    exp_dec(NOP, 32'h04, 32'h08);
    exp_dec(JAL16, 32'h08, 32'h18);
    exp_dec(BEQF, 32'h18, 32'h1C);
    exp_dec(NOP, 32'h1C, 32'h20);
    exp_dec(BEQB, 32'h20, 32'h18);
    exp_dec(BEQF, 32'h18, 32'h1C);
    exp_dec(NOP, 32'h1C, 32'h20);
    exp_dec(BEQB, 32'h20, 32'h18);
    hs_target = hs_target + 9;
    wait_hs(9);
    repeat (4) @(negedge clk);
    check_drained("seq");

    // Decode backpressure: only FIFO_DEPTH fetches may be taken.
    dec_ready = 1'b0;
    base = hs_count;
    req_q = '{32'h18, 32'h1C, 32'h20, 32'h18};
    exp_dec(BEQF, 32'h18, 32'h1C);
    exp_dec(NOP, 32'h1C, 32'h20);
    exp_dec(BEQB, 32'h20, 32'h18);
    exp_dec(BEQF, 32'h18, 32'h1C);
    hs_target = hs_target + 4;
    repeat (5) @(negedge clk);
    #3;
    check32("bp_fetched", hs_count - base, DEPTH);
    check32("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check32("bp_dec_valid", {31'd0, dec_valid}, 32'd1);
    @(negedge clk);
    dec_ready = 1'b1;
    wait_hs(base + 4);
    repeat (4) @(negedge clk);
    check_drained("bp");

    // Redirect one cycle after a handshake with 3-cycle memory.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_lat = 3;
    base = hs_count;
    req_q = '{32'h40, 32'h200};
    exp_dec(NOP, 32'h200, 32'h204);
    hs_target = hs_target + 2;
    wait_hs(base + 1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check32("redir_dec_valid", {31'd0, dec_valid}, 32'd0);
    wait_hs(base + 2);
    repeat (6) @(negedge clk);
    check_drained("redir");

    // Reset while waiting on a response; the stale reply must be ignored.
    @(negedge clk);
    dec_ready = 1'b0;
    mem_lat = 1;
    base = hs_count;
    req_q.push_back(32'h204);
    hs_target = hs_target + 1;
    wait_hs(base + 1);
    @(negedge clk);
    mem_lat = 3;
    req_q.push_back(32'h208);
    hs_target = hs_target + 1;
    wait_hs(base + 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mem_lat = 1;
    dec_ready = 1'b1;
    req_q.push_back(32'h0);
    exp_dec(NOP, 32'h0, 32'h4);
    hs_target = hs_target + 1;
    wait_hs(base + 3);
    repeat (4) @(negedge clk);
    check_drained("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
